// File: rtl/move_stream_tx.sv
// Move buffer and framed byte-stream transmitter: header (move count), two bytes per move, trailer 0xA5.
// Define MOVE_STREAM_CHECKSUM_EN to insert an XOR checksum byte before the trailer.
module move_stream_tx #(
   parameter int DEPTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             init,
   input  logic             gen,
   input  logic             mv_valid,
   input  logic [15:0]      mv_word,
   output logic             mv_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             overflow,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE, HDR, MV_HI, MV_LO, TRL
`ifdef MOVE_STREAM_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

   state_t           state_reg, state_next;
   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [CNT_W-1:0] sent_reg, sent_next;
   logic [7:0]       tx_data_reg, tx_data_next;
   logic             tx_valid_reg, tx_valid_next;
   logic             busy_reg, busy_next;
   logic             overflow_reg, overflow_next;
   logic             gen_q_reg;
`ifdef MOVE_STREAM_CHECKSUM_EN
   logic [7:0]       csum_reg, csum_next;
`endif

   logic [15:0]      mem [DEPTH];
   logic [15:0]      rd_word, rd_word_nx;
   logic [AW-1:0]    rd_ptr_inc;
   logic [CNT_W-1:0] sent_inc, cnt_new;
   logic             hs, wr_en, full, start;
   state_t           tail_state;
   logic [7:0]       tail_data;

   assign hs         = tx_valid_reg & tx_ready;
   assign full       = (count_reg == CNT_W'(DEPTH));
   assign mv_ready   = reset_n & (state_reg == IDLE) & ~full & ~init;
   assign wr_en      = mv_valid & mv_ready;
   assign start      = gen & ~gen_q_reg & (state_reg == IDLE);
   assign rd_ptr_inc = rd_ptr_reg + AW'(1);
   assign sent_inc   = sent_reg + CNT_W'(1);
   assign cnt_new    = wr_en ? count_reg + CNT_W'(1) : count_reg;
   assign rd_word    = mem[rd_ptr_reg];
   assign rd_word_nx = mem[rd_ptr_inc];

   // State and byte that follow the last move byte (or the header of an empty frame).
`ifdef MOVE_STREAM_CHECKSUM_EN
   assign tail_state = CSUM;
   assign tail_data  = csum_reg ^ tx_data_reg;
`else
   assign tail_state = TRL;
   assign tail_data  = 8'hA5;
`endif

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= mv_word;
   end

   always_comb begin
      state_next    = state_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      sent_next     = sent_reg;
      tx_data_next  = tx_data_reg;
      tx_valid_next = tx_valid_reg;
      overflow_next = overflow_reg;
`ifdef MOVE_STREAM_CHECKSUM_EN
      csum_next     = csum_reg;
      if (hs)
         csum_next = csum_reg ^ tx_data_reg;
`endif
      if (init) begin
         state_next    = IDLE;
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
         sent_next     = '0;
         tx_data_next  = 8'h00;
         tx_valid_next = 1'b0;
         overflow_next = 1'b0;
`ifdef MOVE_STREAM_CHECKSUM_EN
         csum_next     = 8'h00;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (wr_en) begin
                  wr_ptr_next = wr_ptr_reg + AW'(1);
                  count_next  = cnt_new;
               end
               if (mv_valid && full)
                  overflow_next = 1'b1;
               if (start) begin
                  state_next    = HDR;
                  tx_valid_next = 1'b1;
                  tx_data_next  = 8'(cnt_new);
                  sent_next     = '0;
`ifdef MOVE_STREAM_CHECKSUM_EN
                  csum_next     = 8'h00;
`endif
               end
            end
            HDR: if (hs) begin
               if (count_reg != '0) begin
                  state_next   = MV_HI;
                  tx_data_next = rd_word[15:8];
               end else begin
                  state_next   = tail_state;
                  tx_data_next = tail_data;
               end
            end
            MV_HI: if (hs) begin
               state_next   = MV_LO;
               tx_data_next = rd_word[7:0];
            end
            MV_LO: if (hs) begin
               rd_ptr_next = rd_ptr_inc;
               sent_next   = sent_inc;
               if (sent_inc < count_reg) begin
                  state_next   = MV_HI;
                  tx_data_next = rd_word_nx[15:8];
               end else begin
                  state_next   = tail_state;
                  tx_data_next = tail_data;
               end
            end
`ifdef MOVE_STREAM_CHECKSUM_EN
            CSUM: if (hs) begin
               state_next   = TRL;
               tx_data_next = 8'hA5;
            end
`endif
            TRL: if (hs) begin
               state_next    = IDLE;
               tx_valid_next = 1'b0;
               tx_data_next  = 8'h00;
               wr_ptr_next   = '0;
               rd_ptr_next   = '0;
               count_next    = '0;
               sent_next     = '0;
            end
            default: state_next = IDLE;
         endcase
      end
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         sent_reg     <= '0;
         tx_data_reg  <= 8'h00;
         tx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         gen_q_reg    <= 1'b0;
`ifdef MOVE_STREAM_CHECKSUM_EN
         csum_reg     <= 8'h00;
`endif
      end else begin
         state_reg    <= state_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         sent_reg     <= sent_next;
         tx_data_reg  <= tx_data_next;
         tx_valid_reg <= tx_valid_next;
         busy_reg     <= busy_next;
         overflow_reg <= overflow_next;
         gen_q_reg    <= gen;
`ifdef MOVE_STREAM_CHECKSUM_EN
         csum_reg     <= csum_next;
`endif
      end
   end

   assign tx_data  = tx_data_reg;
   assign tx_valid = tx_valid_reg;
   assign busy     = busy_reg;
   assign overflow = overflow_reg;
   assign count    = count_reg;

endmodule

// File: tb/tb_move_stream_tx.sv
// Directed bench for move_stream_tx: a queue model builds each expected frame from the moves written,
// and a negedge monitor checks every accepted byte and every stall against it.
module tb_move_stream_tx;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        init = 1'b0;
   logic        gen = 1'b0;
   logic        mv_valid = 1'b0;
   logic [15:0] mv_word = 16'h0000;
   logic        mv_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy;
   logic        overflow;
   logic [6:0]  count;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_log[$];
   logic [15:0] model_moves[$];
   logic        model_ovf = 1'b0;
   bit          ready_mode = 1'b0;

   move_stream_tx #(.DEPTH(DEPTH), .CNT_W(7)) dut (
      .clk(clk), .reset_n(reset_n), .init(init), .gen(gen),
      .mv_valid(mv_valid), .mv_word(mv_word), .mv_ready(mv_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .overflow(overflow), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // tx_ready driver: fixed high, or random when ready_mode is set
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: checks each accepted byte against the model and holds data across stalls
   initial begin
      logic [7:0] held;
      logic [7:0] e;
      bit         stalled;
      stalled = 1'b0;
      held = 8'h00;
      forever begin
         @(negedge clk);
         if (stalled && reset_n) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'(held));
         end
         stalled = 1'b0;
         if (reset_n && tx_valid === 1'b1) begin
            if (tx_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_byte: got 0x%0h, required no byte", tx_data);
               end else begin
                  e = exp_q.pop_front();
                  if (tx_data !== e) begin
                     n_fail++;
                     $display("FAIL stream_byte: got 0x%0h, required 0x%0h", tx_data, e);
                  end
                  rx_log.push_back(tx_data);
               end
            end else begin
               stalled = 1'b1;
               held = tx_data;
            end
         end
      end
   end

   task automatic write_move(logic [15:0] w);
      mv_valid = 1'b1;
      mv_word  = w;
      if (model_moves.size() < DEPTH) model_moves.push_back(w);
      else model_ovf = 1'b1;
      @(posedge clk);
      #1;
      mv_valid = 1'b0;
   endtask

   task automatic start_frame(bit hold);
      logic [7:0] x;
      logic [7:0] hdr;
      hdr = 8'(model_moves.size());
      exp_q.push_back(hdr);
      x = hdr;
      foreach (model_moves[i]) begin
         exp_q.push_back(model_moves[i][15:8]);
         exp_q.push_back(model_moves[i][7:0]);
         x = x ^ model_moves[i][15:8] ^ model_moves[i][7:0];
      end
`ifdef MOVE_STREAM_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      exp_q.push_back(8'hA5);
      model_moves.delete();
      gen = 1'b1;
      @(posedge clk);
      #1;
      check("hdr_valid", 32'(tx_valid), 32'd1);
      check("hdr_byte", 32'(tx_data), 32'(hdr));
      check("busy_on", 32'(busy), 32'd1);
      if (!hold) gen = 1'b0;
   endtask

   task automatic wait_frame(int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_timeout: %0d bytes pending, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      check("busy_off", 32'(busy), 32'd0);
      check("count_clear", 32'(count), 32'd0);
      check("tx_valid_off", 32'(tx_valid), 32'd0);
   endtask

   task automatic check_log(string name, logic [7:0] lit[$]);
      check({name, "_len"}, 32'(rx_log.size()), 32'(lit.size()));
      for (int i = 0; i < lit.size() && i < rx_log.size(); i++)
         check(name, 32'(rx_log[i]), 32'(lit[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] lit[$];

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_mv_ready", 32'(mv_ready), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("mv_ready_idle", 32'(mv_ready), 32'd1);

      // two-move frame
      rx_log.delete();
      write_move(16'h1234);
      write_move(16'hABCD);
      check("count_two", 32'(count), 32'd2);
      start_frame(1'b0);
      wait_frame(20);
`ifdef MOVE_STREAM_CHECKSUM_EN
      lit = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'hA5};
`else
      lit = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hA5};
`endif
      check_log("two_move_bytes", lit);

      // empty frame
      rx_log.delete();
      start_frame(1'b0);
      wait_frame(10);
`ifdef MOVE_STREAM_CHECKSUM_EN
      lit = '{8'h00, 8'h00, 8'hA5};
`else
      lit = '{8'h00, 8'hA5};
`endif
      check_log("empty_bytes", lit);

      // full buffer plus one dropped move
      for (int i = 0; i < DEPTH; i++)
         write_move(16'(i * 16'h0401) ^ 16'h5A00);
      check("count_full", 32'(count), 32'd64);
      check("mv_ready_full", 32'(mv_ready), 32'd0);
      write_move(16'hDEAD);
      check("overflow_set", 32'(overflow), 32'(model_ovf));
      check("count_still_full", 32'(count), 32'd64);
      start_frame(1'b0);
      check("hdr_full_literal", 32'(tx_data), 32'h40);
      wait_frame(400);
      check("overflow_sticky", 32'(overflow), 32'd1);
      init = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
      model_ovf = 1'b0;
      check("overflow_cleared", 32'(overflow), 32'(model_ovf));

      // random backpressure over a three-move frame
      write_move(16'h0102);
      write_move(16'hF0E1);
      write_move(16'h7788);
      ready_mode = 1'b1;
      start_frame(1'b0);
      wait_frame(300);
      ready_mode = 1'b0;
      @(posedge clk);
      #1;

      // init during MV_LO aborts the frame
      write_move(16'h1A2B);
      write_move(16'h3C4D);
      write_move(16'h5E6F);
      start_frame(1'b0);
      @(posedge clk);
      #1;
      check("mv_ready_busy", 32'(mv_ready), 32'd0);
      @(posedge clk);
      #1;
      check("in_mv_lo", 32'(tx_data), 32'h2B);
      init = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
      exp_q.delete();
      check("init_tx_valid", 32'(tx_valid), 32'd0);
      check("init_count", 32'(count), 32'd0);
      check("init_busy", 32'(busy), 32'd0);
      start_frame(1'b0);
      check("hdr_after_init", 32'(tx_data), 32'h00);
      wait_frame(10);

      // gen held high after a frame must not restart
      write_move(16'h4455);
      start_frame(1'b1);
      wait_frame(20);
      repeat (5) @(posedge clk);
      #1;
      check("hold_gen_busy", 32'(busy), 32'd0);
      check("hold_gen_valid", 32'(tx_valid), 32'd0);
      gen = 1'b0;
      @(posedge clk);
      #1;

      // asynchronous reset mid-frame
      write_move(16'h9988);
      write_move(16'h7766);
      start_frame(1'b0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_tx_valid", 32'(tx_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      exp_q.delete();
      model_moves.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_valid", 32'(tx_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      // normal frame after reset
      write_move(16'hBEEF);
      start_frame(1'b0);
      wait_frame(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
